serial_rx_buffer: RTL and testbench
===================================

# serial_rx_buffer

Receive-side buffer and software flow-control stage between the PC UART and the terminal controller. Bytes from the UART RX stream enter a FIFO and drain to the controller at its own pace, so long operations such as scrolling or clearing the screen do not lose characters. The block also owns the UART TX stream: it merges keyboard bytes with XOFF/XON (0x13/0x11) bytes generated from FIFO occupancy, which throttles the host before the FIFO overflows.

## Interface
Parameters:
- DEPTH_LOG2, 6: FIFO depth is 2^DEPTH_LOG2 bytes.
- XOFF_LEVEL, 48: occupancy at or above which XOFF is requested.
- XON_LEVEL, 16: occupancy at or below which XON is requested.
- Legal configurations require XON_LEVEL < XOFF_LEVEL <= 2^DEPTH_LOG2.

Ports:
- i_clk  in  1  system clock (12 MHz); the block has one clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_s_data  in  8  byte from UART RX.
- i_s_valid  in  1  UART RX byte valid.
- o_s_ready  out  1  ready to UART RX.
- o_m_data  out  8  byte to controller.
- o_m_valid  out  1  controller byte valid.
- i_m_ready  in  1  controller ready.
- i_k_data  in  8  keyboard byte.
- i_k_valid  in  1  keyboard byte valid.
- o_k_ready  out  1  keyboard ready.
- o_tx_data  out  8  byte to UART TX.
- o_tx_valid  out  1  UART TX valid.
- i_tx_ready  in  1  UART TX ready.
- o_level  out  DEPTH_LOG2+1  current FIFO occupancy.
- o_overflow  out  1  sticky; a byte was dropped.

## Operation
- FIFO storage:
  - Circular RAM with read and write pointers of DEPTH_LOG2+1 bits; the MSB distinguishes full from empty.
  - Occupancy is the pointer difference, and pointers wrap modulo 2^(DEPTH_LOG2+1).
- Push:
  - o_s_ready is 1 whenever the block is not in reset, so UART RX is never stalled.
  - A push happens on i_s_valid. If the FIFO is full and no pop occurs that cycle, the byte is discarded and o_overflow is set.
  - o_overflow clears only on reset.
- Pop:
  - o_m_valid/o_m_data are registered first-word-fall-through outputs.
  - A pop happens when o_m_valid && i_m_ready.
  - o_m_data is held stable while o_m_valid=1 and i_m_ready=0.
- Simultaneous push and pop:
  - Always legal; occupancy is unchanged.
  - When full, the push is accepted because of the pop.
- Flow-control FSM, four states:
  - RUN: the host may send. Go to REQ_OFF when o_level >= XOFF_LEVEL.
  - REQ_OFF: 0x13 is pending. Go to HELD when 0x13 is loaded into the TX register.
  - HELD: the host is stopped. Go to REQ_ON when o_level <= XON_LEVEL.
  - REQ_ON: 0x11 is pending. Go to RUN when 0x11 is loaded.
  - A pending request is never cancelled. XOFF is sent even if the level drops while waiting.
- TX merge:
  - One output register.
  - When it is empty, or is being emptied this cycle (o_tx_valid && i_tx_ready), it loads the pending flow byte if there is one.
  - Otherwise it loads the keyboard byte; o_k_ready=1 only in that case.
  - A loaded byte is never replaced before i_tx_ready accepts it.

## Timing
- Reset values:
  - Outputs: o_s_ready=0, o_m_valid=0, o_m_data=0, o_tx_valid=0, o_tx_data=0, o_k_ready=0, o_level=0, o_overflow=0.
  - Internal: FSM=RUN, pointers=0.
- Reset asserted mid-operation flushes the FIFO and discards any pending or held TX byte on the next edge.
- FIFO latency: a byte pushed at edge N reaches an empty FIFO output with o_m_valid=1 after edge N+1.
- Throughput: with i_m_ready=1, one byte per cycle.
- o_level updates at the same edge as the push or pop.
- Flow-control latency:
  - The threshold crossing is seen at edge N. REQ_OFF is entered at N+1.
  - 0x13 drives o_tx_valid after N+2 if the TX register is free.
  - Otherwise it follows the in-flight byte immediately.
- Keyboard path latency: 1 cycle from acceptance to o_tx_valid.

## Configuration
- XONXOFF_EN defined: flow-control FSM and TX merge are built as described above.
- XONXOFF_EN undefined:
  - No FSM; 0x11 and 0x13 are never generated.
  - The keyboard passes through combinationally: o_tx_data=i_k_data, o_tx_valid=i_k_valid, o_k_ready=i_tx_ready.
  - The FIFO and o_overflow are unchanged.

## Test plan
- Push 0x41,0x42,0x43 with i_m_ready=1. Required: same order on o_m_data, first byte valid one cycle after the push, o_level returns to 0.
- With i_m_ready=0 and defaults:
  - Push 48 bytes. Required: exactly one 0x13 on TX.
  - Push 16 more. Required: o_level=64, o_overflow=0.
  - Push a 65th byte. Required: the byte is dropped, o_overflow=1, o_level stays 64.
- From full (64), pop and push in the same cycle. Required: o_level stays 64, no overflow, byte order preserved.
- From HELD, drain to 16. Required: exactly one 0x11 on TX. Draining further produces no extra 0x11.
- Keyboard byte 0x61 is held by i_tx_ready=0 while XOFF becomes pending. Required: 0x61 is sent first, then 0x13, then the next keyboard byte. No byte is corrupted or duplicated.
- Without XONXOFF_EN: fill the FIFO past 48. Required: TX carries only keyboard bytes, with zero-cycle keyboard-to-TX latency.

Source files
------------

// File: rtl/serial_rx_buffer.sv
// serial_rx_buffer: UART RX byte FIFO with registered first-word-fall-through output and a TX
// merge stage. Define XONXOFF_EN to build the XON/XOFF flow-control FSM; otherwise keyboard bytes pass straight to TX.
module serial_rx_buffer #(
  parameter int DEPTH_LOG2 = 6,
  parameter int XOFF_LEVEL = 48,
  parameter int XON_LEVEL  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_s_data,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  output logic [7:0]            o_m_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  input  logic [7:0]            i_k_data,
  input  logic                  i_k_valid,
  output logic                  o_k_ready,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0] PTR_ZERO = {(DEPTH_LOG2+1){1'b0}};

  if (!((XON_LEVEL < XOFF_LEVEL) && (XOFF_LEVEL <= DEPTH))) begin : g_bad_cfg
    $error("serial_rx_buffer: need XON_LEVEL < XOFF_LEVEL <= 2**DEPTH_LOG2");
  end

  logic [7:0]          mem_r [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_r;
  logic [DEPTH_LOG2:0] rd_ptr_r;
  logic [DEPTH_LOG2:0] wr_next_s;
  logic [DEPTH_LOG2:0] rd_next_s;
  logic                full_s;
  logic                push_s;
  logic                pop_s;
  logic                drop_s;
  logic                out_avail_s;

  // RX is never stalled outside reset; overflow is detected instead
  assign o_s_ready = ~i_rst;

  // Push/pop decisions and next pointer values
  always_comb begin
    full_s = (wr_ptr_r[DEPTH_LOG2] != rd_ptr_r[DEPTH_LOG2]) &&
             (wr_ptr_r[DEPTH_LOG2-1:0] == rd_ptr_r[DEPTH_LOG2-1:0]);
    pop_s  = o_m_valid && i_m_ready;
    push_s = i_s_valid && (!full_s || pop_s);
    drop_s = i_s_valid && full_s && !pop_s;
    if (push_s) begin
      wr_next_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_next_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_next_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_next_s = rd_ptr_r;
    end
    // A byte written this edge is not yet readable, which gives the one-cycle fall-through latency
    out_avail_s = (wr_ptr_r != rd_next_s);
  end

  // Byte storage; no reset needed since entries are only read once written
  always_ff @(posedge i_clk) begin
    if (push_s && !i_rst) begin
      mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= i_s_data;
    end
  end

  // Pointers, occupancy, registered FWFT output and sticky overflow
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      o_level    <= PTR_ZERO;
      o_m_valid  <= 1'b0;
      o_m_data   <= 8'h00;
      o_overflow <= 1'b0;
    end else begin
      wr_ptr_r  <= wr_next_s;
      rd_ptr_r  <= rd_next_s;
      o_level   <= wr_next_s - rd_next_s;
      o_m_valid <= out_avail_s;
      if (out_avail_s) begin
        o_m_data <= mem_r[rd_next_s[DEPTH_LOG2-1:0]];
      end else begin
        o_m_data <= o_m_data;
      end
      if (drop_s) begin
        o_overflow <= 1'b1;
      end else begin
        o_overflow <= o_overflow;
      end
    end
  end

`ifdef XONXOFF_EN
  localparam int LW = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] XOFF_L = LW'(XOFF_LEVEL);
  localparam logic [DEPTH_LOG2:0] XON_L  = LW'(XON_LEVEL);
  localparam logic [7:0] XOFF_CHAR = 8'h13;
  localparam logic [7:0] XON_CHAR  = 8'h11;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    REQ_OFF = 2'd1,
    HELD    = 2'd2,
    REQ_ON  = 2'd3
  } fc_state_t;

  fc_state_t  fc_state_r;
  logic       tx_load_s;
  logic       flow_pend_s;
  logic [7:0] flow_byte_s;

  // TX register availability and the flow byte a pending request would load
  always_comb begin
    tx_load_s = !o_tx_valid || i_tx_ready;
    case (fc_state_r)
      REQ_OFF: begin
        flow_pend_s = 1'b1;
        flow_byte_s = XOFF_CHAR;
      end
      REQ_ON: begin
        flow_pend_s = 1'b1;
        flow_byte_s = XON_CHAR;
      end
      default: begin
        flow_pend_s = 1'b0;
        flow_byte_s = 8'h00;
      end
    endcase
    // Flow bytes take priority, so the keyboard is only offered a free slot
    o_k_ready = !i_rst && tx_load_s && !flow_pend_s;
  end

  // Flow-control FSM and the single TX output register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fc_state_r <= RUN;
      o_tx_valid <= 1'b0;
      o_tx_data  <= 8'h00;
    end else begin
      case (fc_state_r)
        RUN: begin
          if (o_level >= XOFF_L) fc_state_r <= REQ_OFF;
          else                   fc_state_r <= RUN;
        end
        REQ_OFF: begin
          if (tx_load_s) fc_state_r <= HELD;
          else           fc_state_r <= REQ_OFF;
        end
        HELD: begin
          if (o_level <= XON_L) fc_state_r <= REQ_ON;
          else                  fc_state_r <= HELD;
        end
        REQ_ON: begin
          if (tx_load_s) fc_state_r <= RUN;
          else           fc_state_r <= REQ_ON;
        end
        default: fc_state_r <= RUN;
      endcase

      if (tx_load_s && flow_pend_s) begin
        o_tx_valid <= 1'b1;
        o_tx_data  <= flow_byte_s;
      end else if (tx_load_s) begin
        o_tx_valid <= i_k_valid;
        if (i_k_valid) o_tx_data <= i_k_data;
        else           o_tx_data <= o_tx_data;
      end else begin
        o_tx_valid <= o_tx_valid;
        o_tx_data  <= o_tx_data;
      end
    end
  end
`else
  // Without flow control the keyboard owns the TX stream directly
  assign o_tx_data  = i_k_data;
  assign o_tx_valid = i_k_valid;
  assign o_k_ready  = i_tx_ready;
`endif

endmodule

// File: tb/tb_serial_rx_buffer.sv
// Directed bench for serial_rx_buffer: FIFO ordering, fill/overflow, push+pop at full, reset flush,
// and either XON/XOFF sequencing (XONXOFF_EN) or keyboard pass-through.
module tb_serial_rx_buffer;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_s_data;
  logic       i_s_valid;
  logic       o_s_ready;
  logic [7:0] o_m_data;
  logic       o_m_valid;
  logic       i_m_ready;
  logic [7:0] i_k_data;
  logic       i_k_valid;
  logic       o_k_ready;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       i_tx_ready;
  logic [6:0] o_level;
  logic       o_overflow;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] tx_log[$];

  serial_rx_buffer #(.DEPTH_LOG2(6), .XOFF_LEVEL(48), .XON_LEVEL(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_s_data(i_s_data), .i_s_valid(i_s_valid), .o_s_ready(o_s_ready),
    .o_m_data(o_m_data), .o_m_valid(o_m_valid), .i_m_ready(i_m_ready),
    .i_k_data(i_k_data), .i_k_valid(i_k_valid), .o_k_ready(o_k_ready),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_level(o_level), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  // Log every byte that TX accepts (handshake completes at the following rising edge)
  always @(negedge i_clk) begin
    if (!i_rst && o_tx_valid && i_tx_ready) tx_log.push_back(o_tx_data);
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic int count_byte(input logic [7:0] b);
    int n = 0;
    foreach (tx_log[i]) if (tx_log[i] == b) n++;
    return n;
  endfunction

  initial begin
    logic [7:0] exp_b;
    logic       kacc;
    int         n_kb;

    i_rst = 1'b1; i_s_data = 8'h00; i_s_valid = 1'b0; i_m_ready = 1'b0;
    i_k_data = 8'h00; i_k_valid = 1'b0; i_tx_ready = 1'b0;
    tick(); tick();
    check_vec("rst_s_ready", o_s_ready, 0);
    check_vec("rst_m_valid", o_m_valid, 0);
    check_vec("rst_m_data", o_m_data, 0);
    check_vec("rst_level", o_level, 0);
    check_vec("rst_overflow", o_overflow, 0);
    check_vec("rst_tx_valid", o_tx_valid, 0);
    check_vec("rst_tx_data", o_tx_data, 0);
    check_vec("rst_k_ready", o_k_ready, 0);
    i_rst = 1'b0;
    #1;
    check_vec("s_ready_run", o_s_ready, 1);

    // Three-byte stream with the controller always ready
    i_m_ready = 1'b1; i_s_valid = 1'b1; i_s_data = 8'h41;
    tick();
    check_vec("st1_valid", o_m_valid, 0);
    check_vec("st1_level", o_level, 1);
    i_s_data = 8'h42;
    tick();
    check_vec("st2_valid", o_m_valid, 1);
    check_vec("st2_data", o_m_data, 8'h41);
    check_vec("st2_level", o_level, 2);
    i_s_data = 8'h43;
    tick();
    check_vec("st3_data", o_m_data, 8'h42);
    check_vec("st3_level", o_level, 2);
    i_s_valid = 1'b0;
    tick();
    check_vec("st4_data", o_m_data, 8'h43);
    check_vec("st4_level", o_level, 1);
    tick();
    check_vec("st5_valid", o_m_valid, 0);
    check_vec("st5_level", o_level, 0);

    // Fill to 64 with the controller stalled
    tx_log.delete();
    i_m_ready = 1'b0;
    n_kb = 0;
    for (int k = 0; k < 64; k++) begin
      i_s_valid = 1'b1;
      i_s_data  = 8'(k);
`ifdef XONXOFF_EN
      i_tx_ready = 1'b1;
      tick();
      if (k == 47) check_vec("xoff_lvl48", o_level, 48);
      if (k == 48) check_vec("xoff_n1_txv", o_tx_valid, 0);
      if (k == 49) begin
        check_vec("xoff_n2_txv", o_tx_valid, 1);
        check_vec("xoff_n2_txd", o_tx_data, 8'h13);
      end
`else
      i_k_valid  = k[0];
      i_k_data   = 8'h20 + 8'(k);
      i_tx_ready = k[1];
      if (k[0] && k[1]) n_kb++;
      #1;
      check_vec("pt_tx_valid", o_tx_valid, k[0]);
      check_vec("pt_tx_data", o_tx_data, 8'h20 + 8'(k));
      check_vec("pt_k_ready", o_k_ready, k[1]);
      tick();
`endif
    end
    i_s_valid = 1'b0;
    i_k_valid = 1'b0;
    i_tx_ready = 1'b1;
    check_vec("full_level", o_level, 64);
    check_vec("full_ovf", o_overflow, 0);
    check_vec("full_head", o_m_data, 8'h00);

    // Simultaneous push and pop while full
    i_s_valid = 1'b1; i_s_data = 8'h80; i_m_ready = 1'b1;
    tick();
    i_s_valid = 1'b0; i_m_ready = 1'b0;
    check_vec("pp_level", o_level, 64);
    check_vec("pp_ovf", o_overflow, 0);
    check_vec("pp_head", o_m_data, 8'h01);

    // 65th byte is dropped
    i_s_valid = 1'b1; i_s_data = 8'hEE;
    tick();
    i_s_valid = 1'b0;
    check_vec("ovf_level", o_level, 64);
    check_vec("ovf_flag", o_overflow, 1);
    check_vec("ovf_head", o_m_data, 8'h01);
`ifdef XONXOFF_EN
    check_vec("xoff_count", count_byte(8'h13), 1);
`else
    check_vec("pt_tx_count", tx_log.size(), n_kb);
    check_vec("pt_no_xoff", count_byte(8'h13), 0);
`endif

    // Drain everything and confirm order
    i_m_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      exp_b = (i < 63) ? 8'(i + 1) : 8'h80;
      check_vec("drain_valid", o_m_valid, 1);
      check_vec("drain_data", o_m_data, exp_b);
      tick();
      check_vec("drain_level", o_level, 63 - i);
    end
    i_m_ready = 1'b0;
    check_vec("drained_valid", o_m_valid, 0);
    for (int i = 0; i < 5; i++) tick();
`ifdef XONXOFF_EN
    check_vec("xon_count", count_byte(8'h11), 1);
    check_vec("xoff_total", count_byte(8'h13), 1);
`else
    check_vec("pt_no_xon", count_byte(8'h11), 0);
`endif

    // Reset mid-operation flushes the FIFO and clears overflow
    i_s_valid = 1'b1; i_s_data = 8'h55;
    tick(); tick(); tick();
    i_s_valid = 1'b0;
    check_vec("pre_rst_level", o_level, 3);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check_vec("flush_level", o_level, 0);
    check_vec("flush_valid", o_m_valid, 0);
    check_vec("flush_ovf", o_overflow, 0);

`ifdef XONXOFF_EN
    // Keyboard byte held in TX while XOFF becomes pending
    tx_log.delete();
    i_tx_ready = 1'b0; i_k_valid = 1'b1; i_k_data = 8'h61;
    #1;
    check_vec("kb_ready_free", o_k_ready, 1);
    tick();
    i_k_data = 8'h62;
    for (int k = 0; k < 48; k++) begin
      i_s_valid = 1'b1; i_s_data = 8'(k);
      tick();
    end
    i_s_valid = 1'b0;
    tick(); tick(); tick();
    check_vec("kb_ready_busy", o_k_ready, 0);
    check_vec("kb_held_data", o_tx_data, 8'h61);
    i_tx_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      kacc = o_k_ready && i_k_valid;
      tick();
      if (kacc) i_k_valid = 1'b0;
    end
    check_vec("kb_seq_len", tx_log.size(), 3);
    check_vec("kb_seq0", (tx_log.size() > 0) ? tx_log[0] : 8'hFF, 8'h61);
    check_vec("kb_seq1", (tx_log.size() > 1) ? tx_log[1] : 8'hFF, 8'h13);
    check_vec("kb_seq2", (tx_log.size() > 2) ? tx_log[2] : 8'hFF, 8'h62);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check_vec("kb_rst_txv", o_tx_valid, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
